// File: rtl/clouds_scroll_ctrl.sv
// Clouds layer horizontal scroll controller: autonomous per-frame drift plus
// acknowledged player scroll requests, applied once per frame with modular wrap.
module clouds_scroll_ctrl #(
    parameter int XRES      = 640,
    parameter int DRIFT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       drift_en,
    input  logic       scroll_req,
    input  logic       scroll_dir,
    input  logic [3:0] scroll_step,
    output logic [9:0] xoffset,
    output logic       scroll_ack,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        ACK     = 2'd2,
        WAITLOW = 2'd3
    } state_t;

    localparam logic signed [11:0] XRES_S     = 12'(XRES);
    localparam logic [7:0]         DRIFT_LAST = 8'(DRIFT_DIV - 1);

    state_t            state_r;
    state_t            state_s;
    logic              vsync_r;
    logic              frame_tick_r;
    logic              scroll_ack_r;
    logic [9:0]        xoffset_r;
    logic [9:0]        xoffset_s;
    logic [7:0]        drift_cnt_r;
    logic [7:0]        drift_cnt_s;
    logic              drift_s;
    logic              hold_dir_r;
    logic [3:0]        hold_step_r;
    logic              capture_s;
    logic              apply_s;
    logic signed [5:0] net_s;

    // Net step is at most one modulus away, so a single add/subtract folds it back.
    function automatic logic [9:0] wrap_add(input logic [9:0] cur, input logic signed [5:0] net);
        logic signed [11:0] sum;
        sum = $signed({2'b00, cur}) + $signed({{6{net[5]}}, net});
        if (sum >= XRES_S) begin
            wrap_add = 10'(sum - XRES_S);
        end else if (sum < 12'sd0) begin
            wrap_add = 10'(sum + XRES_S);
        end else begin
            wrap_add = sum[9:0];
        end
    endfunction

    assign xoffset    = xoffset_r;
    assign scroll_ack = scroll_ack_r;
    assign frame_tick = frame_tick_r;

    // Frame edge detector: registered vsync and a registered one-cycle tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_r      <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            vsync_r      <= vsync_in;
            frame_tick_r <= vsync_in & ~vsync_r;
        end
    end

    // Request handshake next-state; a capture on a tick cycle waits for the next tick.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        apply_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (scroll_req) begin
                    state_s   = PEND;
                    capture_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PEND: begin
                if (frame_tick_r) begin
                    state_s = ACK;
                    apply_s = 1'b1;
                end else begin
                    state_s = PEND;
                end
            end
            ACK: begin
                state_s = WAITLOW;
            end
            WAITLOW: begin
                if (!scroll_req) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAITLOW;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake state, captured request and registered acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            hold_dir_r   <= 1'b0;
            hold_step_r  <= 4'd0;
            scroll_ack_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            scroll_ack_r <= (state_s == ACK);
            if (capture_s) begin
                hold_dir_r  <= scroll_dir;
                hold_step_r <= scroll_step;
            end
        end
    end

    // Drift divider: the frame that finds the counter at its last value adds one pixel.
    always_comb begin
        drift_cnt_s = drift_cnt_r;
        drift_s     = 1'b0;
        if (frame_tick_r && drift_en) begin
            if (drift_cnt_r >= DRIFT_LAST) begin
                drift_cnt_s = 8'd0;
                drift_s     = 1'b1;
            end else begin
                drift_cnt_s = drift_cnt_r + 8'd1;
            end
        end else begin
            drift_cnt_s = drift_cnt_r;
        end
    end

    // Net per-frame displacement and wrapped next offset.
    always_comb begin
        net_s = {5'b00000, drift_s};
        if (apply_s) begin
            if (hold_dir_r) begin
                net_s = net_s + $signed({2'b00, hold_step_r});
            end else begin
                net_s = net_s - $signed({2'b00, hold_step_r});
            end
        end else begin
            net_s = {5'b00000, drift_s};
        end
        if (frame_tick_r) begin
            xoffset_s = wrap_add(xoffset_r, net_s);
        end else begin
            xoffset_s = xoffset_r;
        end
    end

    // Offset and drift counter only move on the cycle after a frame tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drift_cnt_r <= 8'd0;
            xoffset_r   <= 10'd0;
        end else begin
            drift_cnt_r <= drift_cnt_s;
            xoffset_r   <= xoffset_s;
        end
    end

endmodule
